// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and constants for the instruction fetch queue
package ifq_pkg;
    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {REQ, WAIT, HOLD} ifq_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } ifq_entry_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & ~PC_W'(3);
    endfunction
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: synchronous FIFO with occupancy count; flush has priority over push and pop
module ifq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       push_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wr <= r_wr + 1'b1;
            if (pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr] <= push_data;
    end

    assign count = r_count;
    assign head  = r_mem[r_rd];
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential fetch over a req/gnt/rvalid port into a small PC+instr FIFO, flushed by redirect.
// Define IFQ_BYPASS_EN to forward a response to decode in the same cycle when the FIFO is empty.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int          I_ADDR_BITS = 6,
    parameter int          DEPTH       = 4,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect,
    input  logic [63:0]            redirect_pc,
    output logic                   imem_req,
    output logic [I_ADDR_BITS-1:0] imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    output logic                   out_valid,
    output logic [31:0]            out_instr,
    output logic [63:0]            out_pc,
    input  logic                   out_ready
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    ifq_state_e      r_state;
    ifq_state_e      w_state_nxt;
    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] r_issued_pc;
    logic            r_drop;
    logic            w_drop_nxt;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_nxt;
    ifq_entry_t      w_head;
    ifq_entry_t      w_resp;
    logic            w_gnt;
    logic            w_resp_ok;
    logic            w_fifo_valid;
    logic            w_byp;
    logic            w_push;
    logic            w_pop;

    assign imem_req     = rst_n && r_state == REQ;
    assign imem_addr    = r_fetch_pc[I_ADDR_BITS-1:0];
    assign w_gnt        = imem_req && imem_gnt;
    assign w_resp_ok    = imem_rvalid && !r_drop && !redirect;
    assign w_resp       = {r_issued_pc, imem_rdata};
    assign w_fifo_valid = w_count != '0;
`ifdef IFQ_BYPASS_EN
    assign w_byp = w_resp_ok && !w_fifo_valid;
`else
    assign w_byp = 1'b0;
`endif
    assign out_valid   = w_fifo_valid || w_byp;
    assign out_instr   = w_fifo_valid ? w_head.instr : w_byp ? w_resp.instr : NOP;
    assign out_pc      = w_fifo_valid ? w_head.pc : w_byp ? w_resp.pc : '0;
    assign w_pop       = w_fifo_valid && out_ready && !redirect;
    assign w_push      = w_resp_ok && !(w_byp && out_ready);
    assign w_count_nxt = redirect ? '0 : w_count + CW'(w_push) - CW'(w_pop);

    // A redirect leaves drop set while any request (old or granted now) is still owed a response
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop && !imem_rvalid;
        if (redirect) begin
            w_state_nxt = REQ;
            w_drop_nxt  = w_gnt || ((r_drop || r_state == WAIT) && !imem_rvalid);
        end else if (r_state == REQ) begin
            w_state_nxt = w_gnt ? WAIT : REQ;
        end else if (r_state == HOLD || imem_rvalid) begin
            w_state_nxt = (w_count_nxt != FULL) ? REQ : HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= REQ;
            r_drop      <= 1'b0;
            r_fetch_pc  <= RESET_PC;
            r_issued_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            if (redirect) r_fetch_pc <= align_pc(redirect_pc);
            else if (w_gnt) r_fetch_pc <= r_fetch_pc + 64'd4;
            if (w_gnt) r_issued_pc <= r_fetch_pc;
        end
    end

    ifq_fifo #(
        .DEPTH(DEPTH),
        .WIDTH($bits(ifq_entry_t))
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (w_push),
        .pop      (w_pop),
        .flush    (redirect),
        .push_data(w_resp),
        .count    (w_count),
        .head     (w_head)
    );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed checks of streaming, backpressure, redirect and stale-response dropping
`timescale 1ns/1ps
module tb_ifetch_queue;
    import ifq_pkg::*;

    localparam int AB = 8;
`ifdef IFQ_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          redirect;
    logic [63:0]   redirect_pc;
    logic          imem_req;
    logic [AB-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [63:0]   out_pc;
    logic          out_ready;

    logic          m_busy = 1'b0;
    int            m_cnt = 0;
    logic [AB-1:0] m_addr = '0;
    int            lat;
    int            n_chk;
    int            n_fail;

    always #5 clk = ~clk;

    ifetch_queue #(.I_ADDR_BITS(AB), .DEPTH(4), .RESET_PC(64'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_ready  (out_ready)
    );

    // memory: grants when idle, answers lat cycles after the grant, word = C0DE0000 | address
    assign imem_gnt    = imem_req && !m_busy;
    assign imem_rvalid = m_busy && m_cnt == 0;
    assign imem_rdata  = 32'hC0DE_0000 | 32'(m_addr);

    always @(posedge clk) begin
        if (!rst_n) m_busy <= 1'b0;
        else if (imem_gnt) begin
            m_busy <= 1'b1;
            m_cnt  <= lat - 1;
            m_addr <= imem_addr;
        end else if (m_busy) begin
            if (m_cnt == 0) m_busy <= 1'b0;
            else m_cnt <= m_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic restart(input int l, input logic rdy);
        @(negedge clk);
        rst_n = 1'b0; redirect = 1'b0; lat = l; out_ready = rdy;
        @(negedge clk);
        #1;
        chk("midrst_req", 64'(imem_req), 64'(0));
        chk("midrst_valid", 64'(out_valid), 64'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1; lat = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", 64'(imem_req), 64'(0));
        chk("rst_addr", 64'(imem_addr), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_instr", 64'(out_instr), 64'(NOP));
        chk("rst_pc", out_pc, 64'(0));
        rst_n = 1'b1;

        // zero-wait streaming: one instruction every two cycles
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("t1_req", 64'(imem_req), 64'(c % 2 == 0));
            chk("t1_valid", 64'(out_valid), 64'(c >= 2 - BYP && (c + BYP) % 2 == 0));
            if (c >= 2 - BYP && (c + BYP) % 2 == 0) begin
                chk("t1_pc", out_pc, 64'((c + BYP - 2) * 2));
                chk("t1_instr", 64'(out_instr), 64'(32'hC0DE_0000 | 32'((c + BYP - 2) * 2)));
            end
            if (c == 2) chk("t1_addr4", 64'(imem_addr), 64'h4);
        end

        // backpressure: fill to DEPTH, HOLD, then drain and resume at 0x10
        restart(1, 1'b0);
        for (int c = 0; c <= 24; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 20) out_ready = 1'b1;
            #1;
            if (c == 8) chk("t2_hold_req", 64'(imem_req), 64'(0));
            if (c == 19) begin
                chk("t2_full_req", 64'(imem_req), 64'(0));
                chk("t2_full_valid", 64'(out_valid), 64'(1));
                chk("t2_full_pc", out_pc, 64'h0);
                chk("t2_next_addr", 64'(imem_addr), 64'h10);
            end
            if (c >= 20) begin
                chk("t2_pop_valid", 64'(out_valid), 64'(1));
                chk("t2_pop_pc", out_pc, 64'((c - 20) * 4));
                chk("t2_pop_instr", 64'(out_instr), 64'(32'hC0DE_0000 | 32'((c - 20) * 4)));
            end
            if (c == 21) begin
                chk("t2_resume_req", 64'(imem_req), 64'(1));
                chk("t2_resume_addr", 64'(imem_addr), 64'h10);
            end
        end

        // redirect to 0x40 while waiting on a 3-cycle memory; the 0x10 response is dropped
        restart(3, 1'b1);
        for (int c = 0; c <= 24 - BYP; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 17) begin redirect = 1'b1; redirect_pc = 64'h40; end
            if (c == 18) redirect = 1'b0;
            #1;
            if (c <= 17) begin
                chk("t3_valid", 64'(out_valid), 64'(c >= 4 - BYP && (c + BYP) % 4 == 0));
                if (c >= 4 - BYP && (c + BYP) % 4 == 0) chk("t3_pc", out_pc, 64'(c + BYP - 4));
            end else if (c < 24 - BYP) begin
                chk("t3_no_stale", 64'(out_valid), 64'(0));
            end else begin
                chk("t3_new_valid", 64'(out_valid), 64'(1));
                chk("t3_new_pc", out_pc, 64'h40);
                chk("t3_new_instr", 64'(out_instr), 64'hC0DE_0040);
            end
            if (c == 17) chk("t3_wait_req", 64'(imem_req), 64'(0));
            if (c == 18) begin
                chk("t3_redir_req", 64'(imem_req), 64'(1));
                chk("t3_redir_addr", 64'(imem_addr), 64'h40);
            end
            if (c == 20) begin
                chk("t3_regnt", 64'(imem_gnt), 64'(1));
                chk("t3_regnt_addr", 64'(imem_addr), 64'h40);
            end
        end

        // redirect with rvalid and 2 queued entries, then redirect to unaligned 0x43
        restart(1, 1'b0);
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 5) begin redirect = 1'b1; redirect_pc = 64'h80; end
            if (c == 6) redirect = 1'b0;
            if (c == 8) begin redirect = 1'b1; redirect_pc = 64'h43; out_ready = 1'b1; end
            if (c == 9) redirect = 1'b0;
            #1;
            if (c == 5) begin
                chk("t4_rvalid", 64'(imem_rvalid), 64'(1));
                chk("t4_head_valid", 64'(out_valid), 64'(1));
                chk("t4_head_pc", out_pc, 64'h0);
            end
            if (c == 6) begin
                chk("t4_flush_valid", 64'(out_valid), 64'(0));
                chk("t4_new_req", 64'(imem_req), 64'(1));
                chk("t4_new_addr", 64'(imem_addr), 64'h80);
            end
            if (c == 8) begin
                chk("t4_kept_valid", 64'(out_valid), 64'(1));
                chk("t4_kept_pc", out_pc, 64'h80);
                chk("t4_kept_instr", 64'(out_instr), 64'hC0DE_0080);
                chk("t5_gnt_on_redir", 64'(imem_gnt), 64'(1));
                chk("t5_gnt_addr", 64'(imem_addr), 64'h84);
            end
            if (c == 9) begin
                chk("t5_flush_valid", 64'(out_valid), 64'(0));
                chk("t5_req", 64'(imem_req), 64'(1));
                chk("t5_addr_aligned", 64'(imem_addr), 64'h40);
                chk("t5_stale_rvalid", 64'(imem_rvalid), 64'(1));
            end
            if (c == 10) begin
                chk("t5_no_stale", 64'(out_valid), 64'(0));
                chk("t5_gnt40", 64'(imem_gnt), 64'(1));
                chk("t5_addr40", 64'(imem_addr), 64'h40);
            end
            if (c == 11) chk("t5_c11_valid", 64'(out_valid), 64'(BYP));
            if (c == 12) begin
                chk("t5_c12_valid", 64'(out_valid), 64'(1 - BYP));
                chk("t5_req44", 64'(imem_req), 64'(1));
                chk("t5_addr44", 64'(imem_addr), 64'h44);
            end
            if (c == 12 - BYP) begin
                chk("t5_pc40", out_pc, 64'h40);
                chk("t5_instr40", 64'(out_instr), 64'hC0DE_0040);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch queue that sits directly upstream of the pipelined datapath's IF/ID register. It generates sequential fetch addresses, issues one request at a time to instruction memory over a req/gnt/rvalid handshake, and buffers returned instructions with their PCs in a small FIFO. It presents them to the decode stage with valid/ready flow control. A taken branch (the datapath's `pc_src` and branch target) flushes the queue and redirects fetch.

## Interface
Parameters:
- `I_ADDR_BITS`, 6: width of the instruction-memory byte address.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 64'h0: first fetch address after reset.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `redirect`, in, 1: taken branch; flush and restart fetch.
- `redirect_pc`, in, 64: new fetch PC; bits [1:0] are ignored and treated as 0.
- `imem_req`, out, 1: fetch request.
- `imem_addr`, out, I_ADDR_BITS: `fetch_pc[I_ADDR_BITS-1:0]`.
- `imem_gnt`, in, 1: memory accepted the request this cycle.
- `imem_rvalid`, in, 1: response valid; at most one is outstanding.
- `imem_rdata`, in, 32: instruction word.
- `out_valid`, out, 1: head entry is valid.
- `out_instr`, out, 32: head instruction; 32'h00000013 (NOP) when `out_valid`=0.
- `out_pc`, out, 64: head PC; 0 when `out_valid`=0.
- `out_ready`, in, 1: decode accepts; this is the datapath's no-stall signal.

## Operation
- FSM states:
  - REQ: `imem_req`=1. On `imem_gnt`, go to WAIT.
  - WAIT: `imem_req`=0. On `imem_rvalid`, go to REQ if a slot is free, else HOLD.
  - HOLD: `imem_req`=0. When a slot frees, go to REQ.
- Slot accounting:
  - A request may be issued only when `count + outstanding < DEPTH`.
  - On entering REQ with no free slot, the FSM goes to HOLD instead.
- On grant, `issued_pc` latches `fetch_pc`, and `fetch_pc` advances by 4 with 64-bit wrap-around.
- Response handling:
  - When `drop`=0, a response pushes `{issued_pc, imem_rdata}`.
  - When `drop`=1, the response is discarded and `drop` clears.
- Pop: when `out_valid && out_ready`. Push and pop in the same cycle leave `count` unchanged. A push never occurs when the FIFO is full, because slot accounting prevents it.
- `redirect` has priority over push and pop in the same cycle:
  - FIFO is cleared and `count` becomes 0.
  - `fetch_pc` takes `{redirect_pc[63:2], 2'b00}`.
  - The FSM goes to REQ.
  - If a request is outstanding, meaning state WAIT or `imem_gnt`=1 this cycle, `drop` is set. It is not cleared unless the matching `rvalid` arrives in that same cycle, in which case that response is simply discarded.
  - An ungranted REQ is not a transaction; its address may change freely.
- In REQ, `imem_addr` is held stable until `gnt`, except on redirect.

## Timing
- Reset: `imem_req`=0, `imem_addr`=`RESET_PC[I_ADDR_BITS-1:0]`, `out_valid`=0, `out_instr`=NOP, `out_pc`=0, state=REQ, `drop`=0, `count`=0.
- First cycle after `rst_n` samples 1: `imem_req`=1.
- Latency from `imem_rvalid` at cycle N to `out_valid` at N+1 (FIFO path).
- Back-to-back throughput: one instruction per `gnt`→`rvalid` round trip, with a minimum of 2 cycles per instruction for zero-wait memory.
- Redirect at cycle N: `imem_req`=1 with the new address at N+1, and `out_valid`=0 at N+1.
- Reset asserted mid-transaction: all state returns to reset values, and no `drop` is kept. Memory is reset by the same `rst_n`.

## Configuration
- `IFQ_BYPASS_EN` defined:
  - Condition: FIFO empty, `drop`=0, `imem_rvalid`=1, `redirect`=0.
  - Effect: `out_valid`, `out_instr` and `out_pc` are driven combinationally from the response in the same cycle.
  - If `out_ready`=1 the entry is not stored; otherwise it is pushed.
  - Latency from `rvalid` to `out_valid` becomes 0 cycles.
- Undefined: always through the FIFO, with 1-cycle latency.

## Structure
- Package `ifq_pkg` holds:
  - the NOP constant 32'h00000013;
  - the FSM state enum {REQ, WAIT, HOLD};
  - `PC_W`=64 and `INSTR_W`=32.
- Sub-module `ifq_fifo`: synchronous FIFO with parameters `DEPTH` and `WIDTH`=96, and ports push, pop, flush, count, head. Flush has priority.

## Test plan
- Reset, zero-wait memory (`gnt` same cycle, `rvalid` next), `out_ready`=1 → `out_pc` sequence 0, 4, 8, 12; `out_instr` matches the memory words; first `out_valid` 3 cycles after reset release.
- `out_ready`=0 held for 20 cycles → FIFO fills to 4, then FSM in HOLD with `imem_req`=0. Release `out_ready` → 4 pops in order, fetching resumes at PC 16.
- Redirect to 0x40 while WAIT, with a 3-cycle memory → stale response dropped, next `out_pc`=0x40, no entry with PC 0x10 appears.
- Redirect and `rvalid` in the same cycle, with FIFO holding 2 entries → `out_valid`=0 next cycle, `drop`=0, request for the new PC issued next cycle.
- `redirect_pc`=0x43 → `imem_addr`=0x40, then 0x44.
- With `IFQ_BYPASS_EN`, empty FIFO, `out_ready`=1 → `out_valid` high in the same cycle as `rvalid`, and `count` stays 0.
